// File: rtl/dcache_pkg.sv
// Shared types and sizing helpers for the direct-mapped write-through data cache.
package dcache_pkg;

  localparam int DEFAULT_LINES = 64;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RESP     = 3'd1,
    S_MRD      = 3'd2,
    S_MRD_WAIT = 3'd3,
    S_MWR      = 3'd4,
    S_MWR_WAIT = 3'd5
  } state_e;

  // Index width: log2 of the line count.
  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Tag width: address bits above the index and the byte offset.
  function automatic int tag_w(input int addr_w, input int lines);
    return addr_w - $clog2(lines) - 2;
  endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Valid/tag/data storage for the cache lines. One combinational read port,
// one synchronous write port; valid bits are cleared asynchronously on reset.
module dcache_line_array
  import dcache_pkg::*;
#(
  parameter int LINES = DEFAULT_LINES,
  parameter int IDX_W = idx_w(DEFAULT_LINES),
  parameter int TAG_W = tag_w(32, DEFAULT_LINES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [IDX_W-1:0] rd_idx,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_valid,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_data
);

  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES];

  // Next valid vector: only the written line can change.
  always_comb begin
    valid_d = valid_q;
    if (wr_en) begin
      valid_d[wr_idx] = wr_valid;
    end else begin
      valid_d = valid_q;
    end
  end

  // Valid bits: the only line state that reset has to clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= {LINES{1'b0}};
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data storage; contents are meaningless while the line is invalid.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is
// defined; otherwise hit_count and miss_count are tied to zero.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int LINES  = DEFAULT_LINES,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
);

  localparam int IDX_W = idx_w(LINES);
  localparam int TAG_W = tag_w(ADDR_W, LINES);
  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              mrd_q, mrd_d;
  logic              mwr_q, mwr_d;

  logic [ADDR_W-3:0] lk_word_s;
  logic [IDX_W-1:0]  lk_idx_s;
  logic [TAG_W-1:0]  lk_tag_s;
  logic              rd_valid_s;
  logic [TAG_W-1:0]  rd_tag_s;
  logic [31:0]       rd_data_s;
  logic              hit_s;
  logic              we_s;
  logic [31:0]       wr_data_s;

  // Lookup address: the live CPU address while idle, the latched one afterwards.
  always_comb begin
    if (state_q == S_IDLE) begin
      lk_word_s = (ADDR_W-2)'(cpu_addr >> 2'd2);
    end else begin
      lk_word_s = (ADDR_W-2)'(addr_q >> 2'd2);
    end
  end

  assign lk_idx_s = lk_word_s[IDX_W-1:0];
  assign lk_tag_s = lk_word_s[ADDR_W-3:IDX_W];
  assign hit_s    = rd_valid_s && (rd_tag_s == lk_tag_s);

  dcache_line_array #(
    .LINES (LINES),
    .IDX_W (IDX_W),
    .TAG_W (TAG_W)
  ) u_lines (
    .clock    (clock),
    .reset    (reset),
    .rd_idx   (lk_idx_s),
    .rd_valid (rd_valid_s),
    .rd_tag   (rd_tag_s),
    .rd_data  (rd_data_s),
    .wr_en    (we_s),
    .wr_idx   (lk_idx_s),
    .wr_valid (1'b1),
    .wr_tag   (lk_tag_s),
    .wr_data  (wr_data_s)
  );

  // Next-state, request latching, line writes and Moore output decode.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    we_s      = 1'b0;
    wr_data_s = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (cpu_write) begin
          // Write wins over a simultaneous read; the read is dropped.
          addr_d  = cpu_addr & WORD_MASK;
          wdata_d = cpu_wdata;
          state_d = S_MWR;
        end else if (cpu_read) begin
          addr_d  = cpu_addr & WORD_MASK;
          wdata_d = cpu_wdata;
          if (hit_s) begin
            rdata_d = rd_data_s;
            state_d = S_RESP;
          end else begin
            state_d = S_MRD;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MRD: begin
        state_d = S_MRD_WAIT;
      end
      S_MRD_WAIT: begin
        if (mem_ready) begin
          we_s      = 1'b1;
          wr_data_s = mem_rdata;
          rdata_d   = mem_rdata;
          state_d   = S_RESP;
        end else begin
          state_d = S_MRD_WAIT;
        end
      end
      S_MWR: begin
        // Write hits keep the line coherent; misses do not allocate.
        if (hit_s) begin
          we_s      = 1'b1;
          wr_data_s = wdata_q;
        end else begin
          we_s = 1'b0;
        end
        state_d = S_MWR_WAIT;
      end
      S_MWR_WAIT: begin
        if (mem_ready) begin
          state_d = S_RESP;
        end else begin
          state_d = S_MWR_WAIT;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    ready_d = (state_d == S_RESP);
    mrd_d   = (state_d == S_MRD);
    mwr_d   = (state_d == S_MWR);
  end

  // State and registered outputs; reset aborts any transaction in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      mrd_q   <= 1'b0;
      mwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      mrd_q   <= mrd_d;
      mwr_q   <= mwr_d;
    end
  end

  assign cpu_rdata = rdata_q;
  assign cpu_ready = ready_q;
  assign mem_addr  = addr_q;
  assign mem_read  = mrd_q;
  assign mem_write = mwr_q;
  assign mem_wdata = wdata_q;

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  // Count read hits sampled in idle and every entry into the fill request.
  always_comb begin
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if ((state_q == S_IDLE) && cpu_read && !cpu_write && hit_s) begin
      hit_count_d = hit_count_q + 32'd1;
    end else begin
      hit_count_d = hit_count_q;
    end
    if ((state_q == S_IDLE) && (state_d == S_MRD)) begin
      miss_count_d = miss_count_q + 32'd1;
    end else begin
      miss_count_d = miss_count_q;
    end
  end

  // Statistics registers, wrapping naturally at 2^32.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count_q  <= 32'd0;
      miss_count_q <= 32'd0;
    end else begin
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`else
  assign hit_count  = 32'd0;
  assign miss_count = 32'd0;
`endif

endmodule
